// File: rtl/riscv_pkg.sv
// Shared types for the 16-bit core pipeline.
package riscv_pkg;

   // Second ALU operand source, selected in decode.
   typedef enum logic {
      ALU_SRC_REG = 1'b0,
      ALU_SRC_IMM = 1'b1
   } alu_src_t;

   // Memory operation carried from execute into the memory stage (3 decodes as MEM_NONE).
   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_op_t;

   // Memory-stage FSM states.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StDone = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: serialises loads/stores to a req/gnt/rvalid data port and
// holds one registered result for writeback behind a valid/ready handshake.
module mem_stage
   import riscv_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [15:0]           alu_data_i,
   input  logic [15:0]           rs2_data_i,
   input  logic [1:0]            mem_op_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic                  wb_en_i,
   input  logic                  flush_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [14:0]           dmem_addr_o,
   output logic [15:0]           dmem_wdata_o,
   input  logic                  dmem_gnt_i,
   input  logic                  dmem_rvalid_i,
   input  logic [15:0]           dmem_rdata_i,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [15:0]           wb_data_o,
   output logic [REG_ADDR_W-1:0] wb_rd_o,
   output logic                  wb_en_o,
   output logic                  misalign_o
);

   mem_state_t            state_q, state_d;
   logic                  kill_q, kill_d;
   logic                  we_q, we_d;
   logic [14:0]           addr_q, addr_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [15:0]           wb_data_q, wb_data_d;
   logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
   logic                  wb_en_q, wb_en_d;
   logic                  misalign_q, misalign_d;

   mem_op_t op;
   logic    is_load, is_store, is_mem, misaligned, accept, killed;

   // Ready/accept decode and next-state for the FSM and the result register.
   always_comb begin
      op         = mem_op_t'(mem_op_i);
      is_load    = (op == MEM_LOAD);
      is_store   = (op == MEM_STORE);
      is_mem     = is_load || is_store;
      misaligned = alu_data_i[0];

      ex_ready_o = ((state_q == StIdle) || ((state_q == StDone) && wb_ready_i)) && !flush_i;
      accept     = ex_valid_i && ex_ready_o;
      // A flush landing in the completion cycle still kills the access.
      killed     = kill_q || flush_i;

      state_d    = state_q;
      kill_d     = kill_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      wb_en_d    = wb_en_q;
      misalign_d = 1'b0;

      case (state_q)
         StIdle: state_d = StIdle;
         StReq: begin
            // Request stays up until granted, even under flush.
            if (flush_i) kill_d = 1'b1;
            if (dmem_gnt_i) begin
               if (we_q) begin
                  state_d = killed ? StIdle : StDone;
                  kill_d  = 1'b0;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (flush_i) kill_d = 1'b1;
            if (dmem_rvalid_i) begin
               wb_data_d = dmem_rdata_i;
               state_d   = killed ? StIdle : StDone;
               kill_d    = 1'b0;
            end
         end
         StDone: begin
            if (flush_i || wb_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Accept overrides the retire-to-idle transition out of DONE.
      if (accept) begin
         we_d       = is_store;
         addr_d     = alu_data_i[15:1];
         wdata_d    = rs2_data_i;
         wb_data_d  = alu_data_i;
         wb_rd_d    = rd_addr_i;
         wb_en_d    = wb_en_i && !is_store && !(is_mem && misaligned);
         misalign_d = is_mem && misaligned;
         state_d    = (is_mem && !misaligned) ? StReq : StDone;
      end
   end

   // FSM state and result/request registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         kill_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_en_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         wb_en_q    <= wb_en_d;
         misalign_q <= misalign_d;
      end
   end

   assign dmem_req_o   = (state_q == StReq);
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdata_q;
   assign wb_valid_o   = (state_q == StDone);
   assign wb_data_o    = wb_data_q;
   assign wb_rd_o      = wb_rd_q;
   assign wb_en_o      = wb_en_q;
   assign misalign_o   = misalign_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit core, directly downstream of the execute-stage ALU. It accepts one instruction per handshake from execute and uses the ALU result either as a data-memory address (load/store) or as a pass-through result. It drives a request/grant/response data-memory port and presents a single registered result to writeback over a valid/ready handshake. Loads and stores are serialized, and the stage applies backpressure to execute while an access is in flight.

## Interface
- `REG_ADDR_W`, default 3: width of the destination register index.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `ex_valid_i`  in  1  execute presents an instruction.
- `ex_ready_o`  out  1  stage accepts the instruction this cycle.
- `alu_data_i`  in  16  ALU result; byte address for loads/stores, result otherwise.
- `rs2_data_i`  in  16  store data.
- `mem_op_i`  in  2  `mem_op_t`: MEM_NONE=0, MEM_LOAD=1, MEM_STORE=2; 3 is treated as MEM_NONE.
- `rd_addr_i`  in  `REG_ADDR_W`  destination register.
- `wb_en_i`  in  1  instruction writes `rd`.
- `flush_i`  in  1  kill the held or in-flight instruction.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  15  word address, `alu_data_i[15:1]`.
- `dmem_wdata_o`  out  16  write data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  16  read data.
- `wb_valid_o`  out  1  result valid to writeback.
- `wb_ready_i`  in  1  writeback accepts.
- `wb_data_o`  out  16  result (load data or ALU result).
- `wb_rd_o`  out  `REG_ADDR_W`  destination register.
- `wb_en_o`  out  1  register-file write enable.
- `misalign_o`  out  1  one-cycle pulse: a load/store had `alu_data_i[0]`=1.

## Operation
- FSM states, `mem_state_t`:
  - IDLE: empty.
  - REQ: `dmem_req_o`=1.
  - WAIT: load awaiting `dmem_rvalid_i`.
  - DONE: result held, `wb_valid_o`=1.
- Ready rule: `ex_ready_o = (IDLE || (DONE && wb_ready_i)) && !flush_i`. An instruction is accepted when `ex_valid_i && ex_ready_o`.
- On accept, all fields are registered. The next state depends on the instruction:
  - MEM_NONE → DONE, `wb_data_o`=`alu_data_i`.
  - Aligned LOAD or STORE → REQ.
  - Misaligned LOAD or STORE → DONE with `wb_en_o`=0. No memory request is issued, and `misalign_o` pulses in the following cycle.
- REQ: `dmem_addr_o`, `dmem_we_o` (STORE) and `dmem_wdata_o` are held stable until `dmem_gnt_i`.
  - STORE: on grant → DONE with `wb_en_o`=0.
  - LOAD: on grant → WAIT.
- WAIT: on `dmem_rvalid_i`, capture `dmem_rdata_i` into `wb_data_o`, then → DONE.
- DONE: if `wb_ready_i`=1, the entry retires. The stage then accepts a new instruction in the same cycle if one is offered, otherwise it goes → IDLE. If `wb_ready_i`=0, all `wb_*` outputs are held.
- `flush_i`:
  - In IDLE/DONE: the stage → IDLE next cycle and the held result is dropped.
  - In REQ/WAIT: the access completes (the request is never withdrawn before grant). A `kill` flag is set, and on completion the stage → IDLE without raising `wb_valid_o`.
  - `flush_i` blocks accept in the same cycle.
- Reset (async, `rst_ni`=0): state IDLE, `kill`=0, and every output is 0 except `ex_ready_o`, which follows the ready rule (1 when `flush_i`=0).

## Timing
- MEM_NONE: accepted in cycle N → `wb_valid_o` in N+1. Back-to-back throughput is 1 per cycle while `wb_ready_i`=1.
- STORE: accepted in N → `dmem_req_o` in N+1. Grant in cycle G (G ≥ N+1) → `wb_valid_o` in G+1.
- LOAD: `dmem_rvalid_i` is guaranteed no earlier than G+1. Response in cycle R → `wb_valid_o` and data in R+1.
- No combinational path from `dmem_*` inputs to `dmem_*` outputs. The only combinational input-to-output path is `wb_ready_i`/`flush_i` to `ex_ready_o`.
- At most one outstanding memory access. `dmem_rvalid_i` outside WAIT is ignored.

## Structure
- Add `mem_op_t` and `mem_state_t` to `riscv_pkg`, next to `alu_src_t`.
- Single module with no sub-modules. The FSM and the result register live in one always_ff, with next-state/ready logic in one always_comb.

## Test plan
- ADD-class op, `alu_data_i`=0x1234, `rd`=5, `wb_en_i`=1, accepted cycle 0 → cycle 1 shows `wb_valid_o`=1, `wb_data_o`=0x1234, `wb_rd_o`=5, `wb_en_o`=1. Back-to-back ops retire one per cycle.
- STORE to 0x0010, data 0xBEEF, grant delayed 3 cycles → `dmem_req_o`/`we`/`addr`=0x0008/`wdata`=0xBEEF stable for all 3 cycles; `wb_valid_o` one cycle after grant with `wb_en_o`=0.
- LOAD from 0x0020, grant cycle 1, rvalid cycle 4 with 0xCAFE → `ex_ready_o`=0 in cycles 1–4; cycle 5 shows `wb_data_o`=0xCAFE, `wb_en_o`=1.
- LOAD to 0x0003 → no `dmem_req_o`, `misalign_o` pulses once, result retires with `wb_en_o`=0.
- `wb_ready_i`=0 for 4 cycles in DONE → `wb_*` outputs constant and `ex_ready_o`=0. Release together with a valid new op → retire and accept in the same cycle.
- `flush_i` during WAIT → read completes, no `wb_valid_o`, stage back in IDLE. Async reset asserted mid-REQ → `dmem_req_o` drops immediately and the FSM is IDLE after release.
